// File: rtl/spin_controller.sv
// Reel/screen sequencer: LFSR spin, stop/auto-stop, settle, win check
// and timed buzzer with a saturating win counter.
module spin_controller #(
  parameter int          NumberOfBits  = 31,
  parameter logic [31:0] Seed          = 32'hACE1_0001,
  parameter int          MinSpinCycles = 4,
  parameter int          MaxSpinCycles = 16,
  parameter int          SettleCycles  = 2,
  parameter int          BuzzCycles    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  win,
  output logic [NumberOfBits:0] ScreenValues,
  output logic                  Buzz,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  result_win,
  output logic [7:0]            win_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SPIN   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] WIN    = 3'd4;

  localparam logic [15:0] MIN_C = 16'(MinSpinCycles);
  localparam logic [15:0] MAX_C = 16'(MaxSpinCycles - 1);
  localparam logic [15:0] SET_C = 16'(SettleCycles - 1);
  localparam logic [15:0] BUZ_C = 16'(BuzzCycles - 1);
  localparam logic [31:0] SEED0 = (Seed == 32'd0) ? 32'd1 : Seed;

  logic [2:0]            state, state_d;
  logic [15:0]           cnt, cnt_d;
  logic [31:0]           lfsr, lfsr_d, lfsr_nx;
  logic [NumberOfBits:0] scr_d;
  logic                  buzz_d, rv_d, rw_d;
  logic [7:0]            wc_d;

  // Galois step; a zero register is recovered to 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    if (v == 32'd0) return 32'd1;
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  assign lfsr_nx = lfsr_step(lfsr);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lfsr_d  = lfsr;
    scr_d   = ScreenValues;
    buzz_d  = Buzz;
    rv_d    = 1'b0;
    rw_d    = result_win;
    wc_d    = win_count;
    case (state)
      IDLE: begin
        buzz_d = 1'b0;
        if (start) begin
          state_d = SPIN;
          cnt_d   = '0;
        end
      end
      SPIN: begin
        if (stop && cnt >= MIN_C) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          lfsr_d = lfsr_nx;
          scr_d  = lfsr_nx[NumberOfBits:0];
          if (cnt == MAX_C) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      SETTLE: begin
        if (cnt == SET_C) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      CHECK: begin
        rv_d = 1'b1;
        rw_d = win;
        if (win) begin
          state_d = WIN;
          buzz_d  = 1'b1;
          cnt_d   = '0;
          wc_d    = (win_count == 8'hFF) ? win_count
                                         : win_count + 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      WIN: begin
        if (stop || cnt == BUZ_C) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        buzz_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lfsr         <= SEED0;
      ScreenValues <= Seed[NumberOfBits:0];
      Buzz         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_win   <= 1'b0;
      win_count    <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      lfsr         <= lfsr_d;
      ScreenValues <= scr_d;
      Buzz         <= buzz_d;
      busy         <= (state_d != IDLE);
      result_valid <= rv_d;
      result_win   <= rw_d;
      win_count    <= wc_d;
    end
  end

endmodule

// File: doc/spin_controller.md
Name: spin_controller

Overview:
- Sequencer for the reel/screen datapath. It generates the 32-bit screen pattern with an LFSR while spinning and freezes it on the player's stop.
- It waits for the registered win checker to settle, then samples the checker's win flag. On a win it drives the buzzer for a fixed time and counts wins.
- Sits between the debounced buttons, the screen driver/win checker, and the buzzer pin.

Parameters:
- NumberOfBits, 31, MSB index of ScreenValues (bus is NumberOfBits+1 bits wide).
- Seed, 32'hACE1_0001, LFSR reset value; a value of 0 is replaced by 1.
- MinSpinCycles, 4, spin cycles before a stop is honoured.
- MaxSpinCycles, 16, forced auto-stop count; must be greater than MinSpinCycles.
- SettleCycles, 2, wait between freeze and win sampling; covers checker register latency.
- BuzzCycles, 8, buzzer on-time in clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle debounced pulse to begin a spin.
- stop  input  1  one-cycle debounced pulse to freeze reels or cancel the buzzer.
- win  input  1  registered win flag from the checker for the current ScreenValues.
- ScreenValues  output  NumberOfBits+1  current screen pattern, registered.
- Buzz  output  1  buzzer drive, registered.
- busy  output  1  high in every state except IDLE.
- result_valid  output  1  one-cycle pulse when a spin result is decided.
- result_win  output  1  result of the last spin; held until the next result_valid.
- win_count  output  8  number of wins, saturating at 255.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, lfsr=Seed (1 if Seed==0), ScreenValues=Seed.
  - Buzz=0, busy=0, result_valid=0, result_win=0, win_count=0, cycle counter=0.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, shifts right.
  - When the output bit is 1, XOR with 32'h8020_0003.
  - Never 0; if 0 is ever detected, load 1.
- IDLE:
  - start=1 -> SPIN, counter cleared.
  - stop is ignored.
  - ScreenValues holds.
- SPIN:
  - Every cycle: lfsr advances, ScreenValues <= the new lfsr value, counter increments.
  - stop=1 with counter>=MinSpinCycles -> SETTLE; there is no advance in the stop cycle, so ScreenValues holds the last value shown.
  - stop below MinSpinCycles is ignored and not remembered.
  - counter==MaxSpinCycles-1 with no stop -> auto-stop: final advance happens, then SETTLE.
  - Exactly MaxSpinCycles advances occur.
  - start is ignored.
- SETTLE:
  - Counter reloaded on entry.
  - ScreenValues frozen for SettleCycles clocks, then CHECK.
  - start and stop are ignored.
- CHECK (1 cycle):
  - Sample win; result_valid=1 and result_win=win, both registered, visible the next cycle.
  - win=1 -> WIN, win_count+1 (held at 255).
  - win=0 -> IDLE.
- WIN:
  - Buzz=1 from the first WIN cycle for BuzzCycles clocks, then Buzz=0 and -> IDLE.
  - stop=1 drops Buzz the next cycle and goes -> IDLE.
  - start is ignored; no queuing.
- Other rules:
  - Simultaneous start and stop in IDLE: start wins and stop is dropped.
  - Reset mid-spin or mid-buzz: Buzz drops asynchronously and the LFSR reloads Seed. win_count is lost.
  - busy is a registered decode of state; result_valid never asserts twice per spin.
  - Unused/illegal state encodings go to IDLE.

Test Plan:
1. Reset with Seed=32'hACE1_0001 -> ScreenValues=32'hACE1_0001, Buzz=0, busy=0, win_count=0. Assert reset mid-WIN -> Buzz=0 in the same cycle, no clock needed.
2. start, no stop, win=0 -> exactly 16 distinct nonzero LFSR values on ScreenValues matching the reference model, 2 frozen settle cycles, result_valid pulse with result_win=0, back to IDLE. busy high for 16+2+1 cycles.
3. start, stop at spin cycle 2 then again at cycle 6 -> first stop ignored, freeze after 6 advances, ScreenValues constant through SETTLE.
4. start, stop at cycle 5, bench drives win=1 -> result_win=1, win_count=1, Buzz high exactly 8 cycles, then IDLE. Repeat to 256 wins -> win_count stays 255.
5. During WIN, pulse stop at buzz cycle 3 -> Buzz low the next cycle, IDLE; a start pulse during WIN is ignored (no spin follows).
6. start and stop in the same IDLE cycle -> SPIN entered and no immediate freeze; start/stop pulses during SETTLE and CHECK have no effect.
